// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry instruction buffer holding {pc, inst} pairs
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~full;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  // Pointers are log2(DEPTH) wide so they wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, imem request FSM and fetch-decode feed; FETCH_STATS_EN adds stat counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned  N        = XLEN,
  parameter int unsigned  DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] NOP      = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_D,
  input  logic         redirect_E,
  input  logic [N-1:0] target_E,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] inst_F,
  output logic [N-1:0] pc_F,
  output logic         flush_F
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_stall
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  rsp_pc_q, rsp_pc_d;
  logic [N-1:0]  last_pc_q;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count;
  logic          full, empty, hs, push, pop;
  fetch_entry_t  head, push_entry;

  assign hs         = imem_req & imem_ready;
  assign push       = (state_q == RUN) & imem_rvalid & ~redirect_E;
  assign pop        = ~empty & ~stall_D & ~redirect_E;
  assign push_entry = '{pc: rsp_pc_q, inst: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_E),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign imem_addr = pc_q;
  assign inst_F    = empty ? NOP : head.inst;
  assign pc_F      = empty ? last_pc_q : head.pc;
  assign flush_F   = empty | redirect_E;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    imem_req   = 1'b0;
    inflight_d = inflight_q + CW'(hs) - CW'(imem_rvalid);
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        // Credit check counts every word that may still land in the buffer.
        imem_req = ~redirect_E & ~full &
                   (({1'b0, inflight_q} + {1'b0, count}) < (CW+1)'(DEPTH));
        if (hs)   pc_d     = pc_q + N'(PC_INC);
        if (push) rsp_pc_d = rsp_pc_q + N'(PC_INC);
      end
      DRAIN: begin
        if (imem_rvalid) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_E) begin
      pc_d     = target_E;
      rsp_pc_d = target_E;
      drop_d   = inflight_d;
      state_d  = (inflight_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      last_pc_q  <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (pop) last_pc_q <= head.pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (pop)                  stat_fetched <= stat_fetched + 32'd1;
      if (empty && !redirect_E) stat_stall   <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based fetch model
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOPW  = 32'h0000_0013;

  logic        clk, rst, stall_D, redirect_E, imem_ready, imem_rvalid;
  logic [31:0] target_E, imem_rdata;
  logic        imem_req, flush_F;
  logic [31:0] imem_addr, inst_F, pc_F;

  fetch_unit #(.N(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOPW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_D     (stall_D),
    .redirect_E  (redirect_E),
    .target_E    (target_E),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_F      (inst_F),
    .pc_F        (pc_F),
    .flush_F     (flush_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  mreq_t       mq[$];
  logic [31:0] bq_pc[$];
  logic [31:0] bq_inst[$];
  logic [31:0] m_pc;
  int          m_inflight, m_drop, cyc, last_due, lat_min, lat_max;
  bit          m_run, m_drain;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    bq_pc.delete();
    bq_inst.delete();
    m_pc = 32'h0;
    m_inflight = 0;
    m_drop = 0;
    m_run = 0;
    m_drain = 0;
  endtask

  // One clock: drive memory, check at negedge, advance model at posedge.
  task automatic cycle();
    bit    rsp, exp_req, hs, can_pop;
    int    lat, due;
    mreq_t m;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid = rsp;
    imem_rdata  = rsp ? word_at(mq[0].addr) : 32'hDEAD_BEEF;
    exp_req = m_run && !m_drain && !redirect_E && (m_inflight + bq_inst.size() < DEPTH);
    @(negedge clk);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("flush_F", {31'b0, flush_F}, {31'b0, (bq_inst.size() == 0) || redirect_E});
    chk("inst_F", inst_F, (bq_inst.size() == 0) ? NOPW : bq_inst[0]);
    if (bq_inst.size() != 0) chk("pc_F", pc_F, bq_pc[0]);
    @(posedge clk);
    hs = exp_req && imem_ready;
    can_pop = (bq_inst.size() != 0) && !stall_D && !redirect_E;
    if (can_pop) begin
      void'(bq_pc.pop_front());
      void'(bq_inst.pop_front());
    end
    if (rsp) begin
      m = mq.pop_front();
      m_inflight--;
      if (m_drain) m_drop--;
      else if (!redirect_E) begin
        bq_pc.push_back(m.addr);
        bq_inst.push_back(word_at(m.addr));
      end
    end
    if (hs) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: m_pc, due: due});
      m_pc += 32'd4;
      m_inflight++;
    end
    if (redirect_E) begin
      bq_pc.delete();
      bq_inst.delete();
      m_pc = target_E;
      m_drop = m_inflight;
      m_drain = (m_drop > 0);
    end else if (m_drain && m_drop == 0) begin
      m_drain = 0;
    end
    m_run = 1;
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_inst", inst_F, NOPW);
    chk("rst_flush", {31'b0, flush_F}, 32'd1);
    chk("rst_pc", pc_F, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit found;
    rst = 1'b0; stall_D = 1'b0; redirect_E = 1'b0; target_E = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc = 0; last_due = 0; lat_min = 1; lat_max = 1;
    model_reset();
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_inst", inst_F, NOPW);
    chk("rst_flush", {31'b0, flush_F}, 32'd1);
    chk("rst_pc", pc_F, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming from reset with 1-cycle memory.
    run(12);

    // Decode back-pressure for 5 cycles.
    stall_D = 1'b1;
    run(5);
    stall_D = 1'b0;
    run(6);

    // Redirect with two requests in flight on 3-cycle memory.
    lat_min = 3; lat_max = 3;
    run(6);
    redirect_E = 1'b1; target_E = 32'h100;
    cycle();
    redirect_E = 1'b0;
    run(12);

    // Redirect colliding with a response while decode stalls.
    lat_min = 1; lat_max = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc) found = 1;
      else cycle();
    end
    chk("rsp_align", {31'b0, found}, 32'd1);
    redirect_E = 1'b1; stall_D = 1'b1; target_E = 32'h100;
    cycle();
    redirect_E = 1'b0; stall_D = 1'b0;
    run(6);

    // Memory refuses requests for 4 cycles.
    imem_ready = 1'b0;
    run(4);
    imem_ready = 1'b1;
    run(4);

    // Address wrap past 2^32.
    redirect_E = 1'b1; target_E = 32'hFFFF_FFF8;
    cycle();
    redirect_E = 1'b0;
    run(8);

    // Randomized traffic with variable latency and rare redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      stall_D    = ($urandom_range(3, 0) == 0);
      imem_ready = ($urandom_range(3, 0) != 0);
      redirect_E = m_run && ($urandom_range(15, 0) == 0);
      target_E   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cycle();
    end
    stall_D = 1'b0; redirect_E = 1'b0; imem_ready = 1'b1;
    run(5);

    // Asynchronous reset in the middle of traffic, then restart.
    mid_reset();
    lat_min = 1; lat_max = 2;
    run(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
